// File: rtl/pc_ctrl.sv
// pc_ctrl: sequencing controller for the PC register and the fetch/decode pipeline.
//
// Chooses between the PC redirect sources (JTAG reset, interrupt, EX jump) and the
// stall sources (EX multi-cycle op, bus stall, JTAG halt). It drives the PC register's
// jump/hold inputs from registered outputs, holds the pipeline for a flush after every
// redirect, and raises an error when a bus stall lasts too long.
//
// Every output is registered. A decision is made from the inputs sampled at one clock
// edge and becomes visible just after that edge.
//
// Ports:
//   clk               clock
//   rst               synchronous active-high reset
//   pc_i              current PC from the PC register
//   ex_jump_req_i     EX branch/jump taken
//   ex_jump_addr_i    EX jump target
//   ex_hold_req_i     EX multi-cycle op busy (level)
//   rib_hold_req_i    bus stall (level)
//   int_req_i         interrupt request (level)
//   int_vec_i         interrupt vector address
//   jtag_halt_req_i   debugger halt (level)
//   jtag_reset_req_i  debugger reset (pulse)
//   jump_flag_o       PC redirect strobe
//   jump_addr_o       PC redirect target
//   hold_flag_o       0=None, 1=Hold_Pc, 2=Hold_If, 3=Hold_Id
//   int_ack_o         interrupt accepted, 1-cycle pulse
//   int_epc_o         return PC captured when an interrupt is accepted
//   jtag_halted_o     core halted
//   bus_err_o         bus stall timeout, 1-cycle pulse

module pc_ctrl #(
    parameter logic [31:0] RESET_ADDR   = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned RESET_CYCLES = 4,
    parameter int unsigned BUS_TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        ex_jump_req_i,
    input  logic [31:0] ex_jump_addr_i,
    input  logic        ex_hold_req_i,
    input  logic        rib_hold_req_i,
    input  logic        int_req_i,
    input  logic [31:0] int_vec_i,
    input  logic        jtag_halt_req_i,
    input  logic        jtag_reset_req_i,
    output logic        jump_flag_o,
    output logic [31:0] jump_addr_o,
    output logic [2:0]  hold_flag_o,
    output logic        int_ack_o,
    output logic [31:0] int_epc_o,
    output logic        jtag_halted_o,
    output logic        bus_err_o
);

    localparam logic [2:0] HoldNone = 3'd0;
    localparam logic [2:0] HoldPc   = 3'd1;
    localparam logic [2:0] HoldId   = 3'd3;

    // The counters count down the remaining cycles, so they hold values up to
    // CYCLES-1 and are reloaded with CYCLES-1.
    localparam int unsigned FlushW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int unsigned RstW   = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [FlushW-1:0] FlushLoad = FlushW'(FLUSH_CYCLES - 1);
    localparam logic [RstW-1:0]   RstLoad   = RstW'(RESET_CYCLES - 1);
    localparam logic [7:0]        BusLimit  = 8'(BUS_TIMEOUT);

    typedef enum logic [1:0] {
        StRun,
        StFlush,
        StHalt,
        StRstSeq
    } state_e;

    state_e              state_q, state_d;
    logic [FlushW-1:0]   flush_cnt_q, flush_cnt_d;
    logic [RstW-1:0]     rst_cnt_q, rst_cnt_d;
    logic [7:0]          bus_cnt_q, bus_cnt_d;

    logic                int_accept;
    logic                jump_accept;
    logic                rst_seq_entry;
    logic                rib_hold_eff;
    logic                bus_hit;

    logic                jump_flag_d;
    logic [31:0]         jump_addr_d;
    logic [2:0]          hold_flag_d;
    logic                int_ack_d;
    logic [31:0]         int_epc_d;
    logic                jtag_halted_d;
    logic                bus_err_d;

    // ------------------------------------------------------------------
    // State register (all state and registered outputs)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StRun;
            flush_cnt_q   <= '0;
            rst_cnt_q     <= '0;
            bus_cnt_q     <= '0;
            jump_flag_o   <= 1'b0;
            jump_addr_o   <= '0;
            hold_flag_o   <= HoldNone;
            int_ack_o     <= 1'b0;
            int_epc_o     <= '0;
            jtag_halted_o <= 1'b0;
            bus_err_o     <= 1'b0;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            rst_cnt_q     <= rst_cnt_d;
            bus_cnt_q     <= bus_cnt_d;
            jump_flag_o   <= jump_flag_d;
            jump_addr_o   <= jump_addr_d;
            hold_flag_o   <= hold_flag_d;
            int_ack_o     <= int_ack_d;
            int_epc_o     <= int_epc_d;
            jtag_halted_o <= jtag_halted_d;
            bus_err_o     <= bus_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic: FSM, flush/reset counters, bus watchdog
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        rst_cnt_d   = rst_cnt_q;
        int_accept  = 1'b0;
        jump_accept = 1'b0;

        unique case (state_q)
            StRun: begin
                if (jtag_reset_req_i) begin
                    state_d   = StRstSeq;
                    rst_cnt_d = RstLoad;
                end else if (int_req_i && !ex_hold_req_i) begin
                    // An interrupt cannot be taken while EX is busy. It stays
                    // pending because the request is a level.
                    int_accept  = 1'b1;
                    state_d     = StFlush;
                    flush_cnt_d = FlushLoad;
                end else if (ex_jump_req_i) begin
                    jump_accept = 1'b1;
                    state_d     = StFlush;
                    flush_cnt_d = FlushLoad;
                end else if (jtag_halt_req_i && !ex_hold_req_i) begin
                    state_d = StHalt;
                end
            end
            StFlush: begin
                if (jtag_reset_req_i) begin
                    state_d   = StRstSeq;
                    rst_cnt_d = RstLoad;
                end else if (flush_cnt_q == '0) begin
                    state_d = StRun;
                end else begin
                    flush_cnt_d = flush_cnt_q - 1'b1;
                end
            end
            StHalt: begin
                if (jtag_reset_req_i) begin
                    state_d   = StRstSeq;
                    rst_cnt_d = RstLoad;
                end else if (!jtag_halt_req_i) begin
                    state_d = StRun;
                end
            end
            StRstSeq: begin
                // A fresh reset request restarts the sequence.
                if (jtag_reset_req_i) begin
                    rst_cnt_d = RstLoad;
                end else if (rst_cnt_q == '0) begin
                    state_d = StRun;
                end else begin
                    rst_cnt_d = rst_cnt_q - 1'b1;
                end
            end
            default: state_d = StRun;
        endcase

        rst_seq_entry = (state_d == StRstSeq) && (state_q != StRstSeq);

        // Watchdog: count consecutive stall cycles and saturate at the limit.
        // The error fires on the cycle the count reaches the limit, and that
        // cycle is still a held cycle. After it, the stall is ignored until
        // the request drops.
        rib_hold_eff = rib_hold_req_i && (bus_cnt_q < BusLimit);
        bus_hit      = rib_hold_req_i && (bus_cnt_q == BusLimit - 8'd1);
        if (!rib_hold_req_i) begin
            bus_cnt_d = '0;
        end else if (bus_cnt_q >= BusLimit) begin
            bus_cnt_d = bus_cnt_q;
        end else begin
            bus_cnt_d = bus_cnt_q + 8'd1;
        end
        if (rst_seq_entry) begin
            bus_cnt_d = '0;
        end
    end

    // ------------------------------------------------------------------
    // Output logic: the values the output registers load at the next edge
    // ------------------------------------------------------------------
    always_comb begin
        jump_flag_d   = 1'b0;
        jump_addr_d   = '0;
        hold_flag_d   = HoldNone;
        int_ack_d     = 1'b0;
        int_epc_d     = int_epc_o;
        jtag_halted_d = 1'b0;
        bus_err_d     = bus_hit && !rst_seq_entry;

        unique case (state_d)
            StRstSeq: begin
                jump_flag_d = 1'b1;
                jump_addr_d = RESET_ADDR;
                hold_flag_d = HoldId;
            end
            StFlush: begin
                hold_flag_d = HoldId;
                if (int_accept) begin
                    jump_flag_d = 1'b1;
                    jump_addr_d = int_vec_i;
                    int_ack_d   = 1'b1;
                    // A jump taken in the same cycle is dropped. Its target
                    // becomes the return address so the jump is not lost.
                    int_epc_d   = ex_jump_req_i ? ex_jump_addr_i : pc_i;
                end else if (jump_accept) begin
                    jump_flag_d = 1'b1;
                    jump_addr_d = ex_jump_addr_i;
                end
            end
            StHalt: begin
                hold_flag_d   = HoldId;
                jtag_halted_d = 1'b1;
            end
            StRun: begin
                if (ex_hold_req_i) begin
                    hold_flag_d = HoldId;
                end else if (rib_hold_eff) begin
                    hold_flag_d = HoldPc;
                end
            end
            default: hold_flag_d = HoldNone;
        endcase
    end

endmodule

// File: tb/tb_pc_ctrl.sv
module tb_pc_ctrl;

    localparam logic [31:0] RST_ADDR = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        ex_jump_req_i;
    logic [31:0] ex_jump_addr_i;
    logic        ex_hold_req_i;
    logic        rib_hold_req_i;
    logic        int_req_i;
    logic [31:0] int_vec_i;
    logic        jtag_halt_req_i;
    logic        jtag_reset_req_i;
    logic        jump_flag_o;
    logic [31:0] jump_addr_o;
    logic [2:0]  hold_flag_o;
    logic        int_ack_o;
    logic [31:0] int_epc_o;
    logic        jtag_halted_o;
    logic        bus_err_o;

    pc_ctrl #(
        .RESET_ADDR  (RST_ADDR),
        .FLUSH_CYCLES(2),
        .RESET_CYCLES(4),
        .BUS_TIMEOUT (255)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pc_i            (pc_i),
        .ex_jump_req_i   (ex_jump_req_i),
        .ex_jump_addr_i  (ex_jump_addr_i),
        .ex_hold_req_i   (ex_hold_req_i),
        .rib_hold_req_i  (rib_hold_req_i),
        .int_req_i       (int_req_i),
        .int_vec_i       (int_vec_i),
        .jtag_halt_req_i (jtag_halt_req_i),
        .jtag_reset_req_i(jtag_reset_req_i),
        .jump_flag_o     (jump_flag_o),
        .jump_addr_o     (jump_addr_o),
        .hold_flag_o     (hold_flag_o),
        .int_ack_o       (int_ack_o),
        .int_epc_o       (int_epc_o),
        .jtag_halted_o   (jtag_halted_o),
        .bus_err_o       (bus_err_o)
    );

    always #5 clk = ~clk;

    // Packed order: jf, ja, hold, ack, epc, halted, berr.
    typedef struct packed {
        logic        jf;
        logic [31:0] ja;
        logic [2:0]  hold;
        logic        ack;
        logic [31:0] epc;
        logic        halted;
        logic        berr;
    } out_t;

    out_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_epc = '0;
    out_t        got;
    out_t        want;

    function automatic out_t mk(input logic jf, input logic [31:0] ja, input logic [2:0] hold,
                                input logic ack, input logic halted, input logic berr);
        out_t r;
        r.jf     = jf;
        r.ja     = ja;
        r.hold   = hold;
        r.ack    = ack;
        r.epc    = exp_epc;
        r.halted = halted;
        r.berr   = berr;
        return r;
    endfunction

    function automatic out_t sample();
        out_t r;
        r.jf     = jump_flag_o;
        r.ja     = jump_addr_o;
        r.hold   = hold_flag_o;
        r.ack    = int_ack_o;
        r.epc    = int_epc_o;
        r.halted = jtag_halted_o;
        r.berr   = bus_err_o;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        pc_i             = '0;
        ex_jump_req_i    = 1'b0;
        ex_jump_addr_i   = '0;
        ex_hold_req_i    = 1'b0;
        rib_hold_req_i   = 1'b0;
        int_req_i        = 1'b0;
        int_vec_i        = '0;
        jtag_halt_req_i  = 1'b0;
        jtag_reset_req_i = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) rst = 1'b0;
            exp_q.push_back(mk(1'b0, '0, 3'd0, 1'b0, 1'b0, 1'b0));
            tick();
            got  = sample();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reset cycle %0d: got %h expected %h", i, got, want);
            end
        end
    endtask

    task automatic test_jump();
        for (int i = 0; i < 4; i++) begin
            clear_inputs();
            case (i)
                0: begin
                    ex_jump_req_i  = 1'b1;
                    ex_jump_addr_i = 32'h0000_0100;
                    exp_q.push_back(mk(1'b1, 32'h0000_0100, 3'd3, 1'b0, 1'b0, 1'b0));
                end
                1: begin
                    // A second jump during the flush is ignored.
                    ex_jump_req_i  = 1'b1;
                    ex_jump_addr_i = 32'h0000_0300;
                    exp_q.push_back(mk(1'b0, '0, 3'd3, 1'b0, 1'b0, 1'b0));
                end
                default: exp_q.push_back(mk(1'b0, '0, 3'd0, 1'b0, 1'b0, 1'b0));
            endcase
            tick();
            got  = sample();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL jump cycle %0d: got %h expected %h", i, got, want);
            end
        end
    endtask

    task automatic test_interrupt();
        for (int i = 0; i < 9; i++) begin
            clear_inputs();
            pc_i      = 32'h0000_0040;
            int_vec_i = 32'h0000_0080;
            case (i)
                0: begin
                    int_req_i      = 1'b1;
                    ex_jump_req_i  = 1'b1;
                    ex_jump_addr_i = 32'h0000_0200;
                    exp_epc        = 32'h0000_0200;
                    exp_q.push_back(mk(1'b1, 32'h0000_0080, 3'd3, 1'b1, 1'b0, 1'b0));
                end
                1: exp_q.push_back(mk(1'b0, '0, 3'd3, 1'b0, 1'b0, 1'b0));
                3, 4, 5: begin
                    int_req_i     = 1'b1;
                    ex_hold_req_i = 1'b1;
                    pc_i          = 32'h0000_0044;
                    exp_q.push_back(mk(1'b0, '0, 3'd3, 1'b0, 1'b0, 1'b0));
                end
                6: begin
                    int_req_i = 1'b1;
                    pc_i      = 32'h0000_0044;
                    exp_epc   = 32'h0000_0044;
                    exp_q.push_back(mk(1'b1, 32'h0000_0080, 3'd3, 1'b1, 1'b0, 1'b0));
                end
                7: exp_q.push_back(mk(1'b0, '0, 3'd3, 1'b0, 1'b0, 1'b0));
                default: exp_q.push_back(mk(1'b0, '0, 3'd0, 1'b0, 1'b0, 1'b0));
            endcase
            tick();
            got  = sample();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL interrupt cycle %0d: got %h expected %h", i, got, want);
            end
        end
    endtask

    task automatic test_halt_and_jtag_reset();
        for (int i = 0; i < 23; i++) begin
            clear_inputs();
            if (i < 10) begin
                jtag_halt_req_i = 1'b1;
                if (i == 4) begin
                    ex_jump_req_i  = 1'b1;
                    ex_jump_addr_i = 32'h0000_0500;
                    int_req_i      = 1'b1;
                    int_vec_i      = 32'h0000_0090;
                end
                exp_q.push_back(mk(1'b0, '0, 3'd3, 1'b0, 1'b1, 1'b0));
            end else if (i == 10 || i == 15 || i == 22) begin
                exp_q.push_back(mk(1'b0, '0, 3'd0, 1'b0, 1'b0, 1'b0));
            end else begin
                // Reset pulses at 11, 16, and 18. The pulse at 18 restarts the count.
                jtag_reset_req_i = (i == 11 || i == 16 || i == 18);
                exp_q.push_back(mk(1'b1, RST_ADDR, 3'd3, 1'b0, 1'b0, 1'b0));
            end
            tick();
            got  = sample();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL halt_jtag_reset cycle %0d: got %h expected %h", i, got, want);
            end
        end
    endtask

    task automatic test_bus_watchdog();
        for (int k = 1; k <= 307; k++) begin
            clear_inputs();
            if (k <= 300) begin
                rib_hold_req_i = 1'b1;
                exp_q.push_back(mk(1'b0, '0, (k <= 255) ? 3'd1 : 3'd0, 1'b0, 1'b0, k == 255));
            end else if (k == 301 || k == 307) begin
                exp_q.push_back(mk(1'b0, '0, 3'd0, 1'b0, 1'b0, 1'b0));
            end else begin
                // A new stall with a jump in the middle still redirects.
                rib_hold_req_i = 1'b1;
                if (k == 304) begin
                    ex_jump_req_i  = 1'b1;
                    ex_jump_addr_i = 32'h0000_0600;
                    exp_q.push_back(mk(1'b1, 32'h0000_0600, 3'd3, 1'b0, 1'b0, 1'b0));
                end else if (k == 305) begin
                    exp_q.push_back(mk(1'b0, '0, 3'd3, 1'b0, 1'b0, 1'b0));
                end else begin
                    exp_q.push_back(mk(1'b0, '0, 3'd1, 1'b0, 1'b0, 1'b0));
                end
            end
            tick();
            got  = sample();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL bus_watchdog cycle %0d: got %h expected %h", k, got, want);
            end
        end
    endtask

    task automatic test_reset_mid_sequence();
        for (int i = 0; i < 10; i++) begin
            clear_inputs();
            rst = 1'b0;
            case (i)
                0: begin
                    ex_jump_req_i  = 1'b1;
                    ex_jump_addr_i = 32'h0000_0100;
                    exp_q.push_back(mk(1'b1, 32'h0000_0100, 3'd3, 1'b0, 1'b0, 1'b0));
                end
                1, 5, 8: begin
                    rst             = 1'b1;
                    jtag_halt_req_i = (i == 8);
                    exp_epc         = '0;
                    exp_q.push_back(mk(1'b0, '0, 3'd0, 1'b0, 1'b0, 1'b0));
                end
                3: begin
                    jtag_reset_req_i = 1'b1;
                    exp_q.push_back(mk(1'b1, RST_ADDR, 3'd3, 1'b0, 1'b0, 1'b0));
                end
                4: exp_q.push_back(mk(1'b1, RST_ADDR, 3'd3, 1'b0, 1'b0, 1'b0));
                7: begin
                    jtag_halt_req_i = 1'b1;
                    exp_q.push_back(mk(1'b0, '0, 3'd3, 1'b0, 1'b1, 1'b0));
                end
                default: exp_q.push_back(mk(1'b0, '0, 3'd0, 1'b0, 1'b0, 1'b0));
            endcase
            tick();
            got  = sample();
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reset_mid_seq cycle %0d: got %h expected %h", i, got, want);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_jump();
        test_interrupt();
        test_halt_and_jtag_reset();
        test_bus_watchdog();
        test_reset_mid_sequence();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_ctrl.md
Name: pc_ctrl

Overview:
- Sequencing controller for the PC register and fetch/decode pipeline.
- Arbitrates PC redirect sources (JTAG reset, interrupt, EX jump) and stall sources (EX multi-cycle op, bus stall, JTAG halt).
- Drives the PC register's jump_flag/jump_addr/hold_flag inputs from registered outputs, sequences post-redirect flush, and watchdogs bus stalls.

Parameters:
- RESET_ADDR, 32'h0000_0000, PC target for JTAG-initiated reset.
- FLUSH_CYCLES, 2, total cycles of ID-level hold starting with the redirect cycle (>=1).
- RESET_CYCLES, 4, cycles the RST_SEQ state is held (>=1).
- BUS_TIMEOUT, 255, consecutive rib_hold_req_i cycles before bus_err_o fires (8-bit counter).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- pc_i  in  32  current PC from PC register
- ex_jump_req_i  in  1  EX branch/jump taken
- ex_jump_addr_i  in  32  EX jump target
- ex_hold_req_i  in  1  EX multi-cycle op busy (level)
- rib_hold_req_i  in  1  bus stall (level)
- int_req_i  in  1  interrupt request (level)
- int_vec_i  in  32  interrupt vector address
- jtag_halt_req_i  in  1  debugger halt (level)
- jtag_reset_req_i  in  1  debugger reset (pulse)
- jump_flag_o  out  1  PC redirect strobe
- jump_addr_o  out  32  PC redirect target
- hold_flag_o  out  3  0=None, 1=Hold_Pc, 2=Hold_If, 3=Hold_Id
- int_ack_o  out  1  interrupt accepted, 1-cycle pulse
- int_epc_o  out  32  return PC captured on acceptance
- jtag_halted_o  out  1  core halted
- bus_err_o  out  1  bus stall timeout, 1-cycle pulse

Behaviour:
- clk and rst are as stated above. All outputs registered; each decision is made from inputs sampled at edge N and is visible after edge N.
- Reset (rst=1 at an edge): state=RUN; all outputs 0; flush and timeout counters 0. Reset wins over every other input, including mid-RST_SEQ/FLUSH/HALT.
- States: RUN, FLUSH, HALT, RST_SEQ.
- Priority in RUN (highest first): jtag_reset_req_i > int_req_i > ex_jump_req_i > jtag_halt_req_i > plain holds.
- RUN, jtag_reset_req_i=1: enter RST_SEQ.
- RUN, int_req_i=1 and ex_hold_req_i=0: accept the interrupt.
  - Next cycle: jump_flag_o=1, jump_addr_o=int_vec_i, int_ack_o=1.
  - int_epc_o=ex_jump_addr_i if ex_jump_req_i was also 1 (jump discarded, its target saved), else pc_i.
  - Enter FLUSH.
- int_req_i with ex_hold_req_i=1: deferred; no ack while EX is busy.
- RUN, ex_jump_req_i=1 (no accepted interrupt): next cycle jump_flag_o=1, jump_addr_o=ex_jump_addr_i; enter FLUSH.
- Redirect cycle: hold_flag_o=3.
- FLUSH: hold_flag_o=3, jump_flag_o=0 for FLUSH_CYCLES-1 further cycles, then RUN.
  - FLUSH_CYCLES=1: return to RUN directly after the redirect cycle.
  - ex_jump_req_i and int_req_i are ignored in FLUSH; int_req_i remains pending because it is level.
  - jtag_reset_req_i in FLUSH goes to RST_SEQ.
- RUN, jtag_halt_req_i=1 and ex_hold_req_i=0 (no higher event): enter HALT.
- HALT: hold_flag_o=3, jtag_halted_o=1.
  - Interrupts and jumps are ignored.
  - jtag_halt_req_i=0 returns to RUN next cycle with jtag_halted_o=0.
  - jtag_reset_req_i goes to RST_SEQ.
- RST_SEQ: jump_flag_o=1, jump_addr_o=RESET_ADDR, hold_flag_o=3 for RESET_CYCLES cycles, then RUN.
  - All other requests ignored.
  - jtag_halted_o=0.
  - The bus timeout counter is cleared on entry.
  - jtag_reset_req_i while already in RST_SEQ restarts the count.
- RUN hold with no redirect/halt: hold_flag_o = max(ex_hold_req_i ? 3 : 0, rib_hold_eff ? 1 : 0).
- Bus watchdog: the counter increments each cycle rib_hold_req_i=1 and clears when it is 0.
  - When it reaches BUS_TIMEOUT: bus_err_o pulses 1 cycle and rib_hold_eff is forced 0 until rib_hold_req_i deasserts.
  - The counter saturates; there is no wrap and no repeat pulse.
- rib_hold_req_i does not block redirects; a jump during a bus stall still redirects.

Test Plan:
- Reset then idle → all outputs 0, hold_flag_o=0.
- ex_jump_req_i=1 for 1 cycle with ex_jump_addr_i=32'h0000_0100, FLUSH_CYCLES=2 → next cycle jump_flag_o=1, jump_addr_o=0x100, hold_flag_o=3; following cycle hold_flag_o=3, jump_flag_o=0; then hold_flag_o=0.
- int_req_i=1, int_vec_i=0x80, ex_jump_req_i=1 to 0x200 in the same cycle → jump_addr_o=0x80, int_ack_o=1, int_epc_o=0x200. Repeat with ex_hold_req_i=1 for 3 cycles → ack delayed until after ex_hold_req_i drops, epc=pc_i.
- jtag_halt_req_i=1 for 10 cycles, pulse ex_jump_req_i mid-halt → jtag_halted_o=1, hold_flag_o=3, no jump_flag_o; release → RUN. Then jtag_reset_req_i pulse → jump_flag_o=1, jump_addr_o=RESET_ADDR for 4 cycles.
- rib_hold_req_i=1 for 300 cycles, BUS_TIMEOUT=255 → hold_flag_o=1 for 255 cycles, bus_err_o single pulse, then hold_flag_o=0 while the request stays high.
- rst asserted mid-FLUSH and mid-RST_SEQ → next cycle all outputs 0, state RUN.
